// File: rtl/dsp_pkg.sv
// dsp_pkg: shared widths, saturation limits and output FIFO entry layout
package dsp_pkg;
  localparam int P_W_DEF = 48;
  localparam int OUT_W_DEF = 18;
  localparam logic [OUT_W_DEF-1:0] OUT_MAX = {1'b0, {(OUT_W_DEF-1){1'b1}}};
  localparam logic [OUT_W_DEF-1:0] OUT_MIN = {1'b1, {(OUT_W_DEF-1){1'b0}}};
  typedef struct packed {
    logic [OUT_W_DEF-1:0] data;
    logic carry;
    logic sat;
  } out_entry_t;
endpackage

// File: rtl/dsp_out_fifo.sv
// dsp_out_fifo: first-word fall-through FIFO, head gated to zero when empty
module dsp_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 20
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     wr,
  input  logic [W-1:0]             wdata,
  input  logic                     rd,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic pop;
  assign valid = count != '0;
  assign pop = rd && valid;
  assign rdata = valid ? mem[rp] : '0;
  always_ff @(posedge CLK)
    if (wr) mem[wp] <= wdata;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
endmodule

// File: rtl/dsp_out_stage.sv
// dsp_out_stage: round, shift and saturate DSP P words into a credit-flowed output FIFO
module dsp_out_stage
  import dsp_pkg::*;
#(
  parameter int P_W = P_W_DEF,
  parameter int SHIFT = 12,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [P_W-1:0]   IN_P,
  input  logic             IN_CARRY,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [OUT_W-1:0] OUT_DATA,
  output logic             OUT_CARRY,
  output logic             OUT_SAT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  input  logic             CLR_CNT,
  output logic [15:0]      SAT_CNT
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic signed [P_W:0] RND = SHIFT == 0 ? '0 : (P_W+1)'(1) << (SHIFT == 0 ? 0 : SHIFT - 1);
  localparam logic signed [P_W:0] MAXV = {{(P_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [P_W:0] MINV = {{(P_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
  logic signed [P_W:0] s1, sh;
  logic s1_v, s1_c, s2_v, s2_c, s2_sat, sat_nx;
  logic [OUT_W-1:0] s2_d, d_nx;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic [OUT_W+1:0] head;
  // in-flight samples hold credit so a full FIFO can never be overrun
  assign occ = {1'b0, count} + (CW+1)'(s1_v) + (CW+1)'(s2_v);
  assign IN_READY = RST_N && occ < (CW+1)'(DEPTH);
  always_comb begin
    sh = s1 >>> SHIFT;
    sat_nx = sh > MAXV || sh < MINV;
    d_nx = sh > MAXV ? MAXV[OUT_W-1:0] : sh < MINV ? MINV[OUT_W-1:0] : sh[OUT_W-1:0];
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      s1 <= '0;
      s1_v <= 1'b0;
      s1_c <= 1'b0;
      s2_d <= '0;
      s2_v <= 1'b0;
      s2_c <= 1'b0;
      s2_sat <= 1'b0;
    end else begin
      s1 <= $signed({IN_P[P_W-1], IN_P}) + RND;
      s1_v <= IN_VALID && IN_READY;
      s1_c <= IN_CARRY;
      s2_d <= d_nx;
      s2_v <= s1_v;
      s2_c <= s1_c;
      s2_sat <= sat_nx;
    end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) SAT_CNT <= '0;
    else if (CLR_CNT) SAT_CNT <= '0;
    else if (s2_v && s2_sat && SAT_CNT != 16'hFFFF) SAT_CNT <= SAT_CNT + 16'd1;
  dsp_out_fifo #(.DEPTH(DEPTH), .W(OUT_W + 2)) u_fifo (
    .CLK(CLK),
    .RST_N(RST_N),
    .wr(s2_v),
    .wdata({s2_d, s2_c, s2_sat}),
    .rd(OUT_READY),
    .rdata(head),
    .valid(OUT_VALID),
    .count(count)
  );
  assign {OUT_DATA, OUT_CARRY, OUT_SAT} = head;
endmodule

// File: tb/tb_dsp_out_stage.sv
// tb_dsp_out_stage: scoreboard bench for the round/saturate output stage
module tb_dsp_out_stage;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic [47:0] IN_P;
  logic IN_CARRY, IN_VALID, IN_READY, OUT_CARRY, OUT_SAT, OUT_VALID, OUT_READY, CLR_CNT;
  logic [17:0] OUT_DATA;
  logic [15:0] SAT_CNT;
  typedef struct packed { logic [17:0] d; logic c; logic s; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, n_acc = 0, n_out = 0, sat_exp = 0;

  dsp_out_stage dut (
    .CLK(CLK), .RST_N(RST_N), .IN_P(IN_P), .IN_CARRY(IN_CARRY), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .OUT_DATA(OUT_DATA), .OUT_CARRY(OUT_CARRY), .OUT_SAT(OUT_SAT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .CLR_CNT(CLR_CNT), .SAT_CNT(SAT_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(logic [47:0] p, logic c);
    exp_t r;
    logic signed [48:0] x;
    x = $signed({p[47], p}) + 49'sd2048;
    x = x >>> 12;
    r.c = c;
    r.s = x > 49'sd131071 || x < -49'sd131072;
    r.d = x > 49'sd131071 ? 18'h1FFFF : x < -49'sd131072 ? 18'h20000 : x[17:0];
    return r;
  endfunction

  // handshakes complete on the following rising edge; inputs change only at posedge+1
  always @(negedge CLK)
    if (RST_N) begin
      if (IN_VALID && IN_READY) begin
        q.push_back(model(IN_P, IN_CARRY));
        n_acc++;
      end
      if (OUT_VALID && OUT_READY) begin
        exp_t e;
        n_out++;
        if (q.size() == 0) chk("spurious_out", 64'(OUT_DATA), 64'hDEAD);
        else begin
          e = q.pop_front();
          chk("out_data", 64'(OUT_DATA), 64'(e.d));
          chk("out_carry", 64'(OUT_CARRY), 64'(e.c));
          chk("out_sat", 64'(OUT_SAT), 64'(e.s));
          if (e.s) sat_exp++;
        end
      end
    end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(logic [47:0] p, logic c);
    int t = 0;
    IN_P = p;
    IN_CARRY = c;
    IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 200) chk("send_timeout", 64'(t), 64'd0);
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || OUT_VALID) && t < 100) begin
      tick();
      t++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, a, o, stalls, idx, v;
    IN_P = '0; IN_CARRY = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1; CLR_CNT = 1'b0;
    repeat (3) tick();
    @(negedge CLK);
    chk("rst_in_ready", 64'(IN_READY), 64'd0);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_out_data", 64'(OUT_DATA), 64'd0);
    chk("rst_out_carry", 64'(OUT_CARRY), 64'd0);
    chk("rst_out_sat", 64'(OUT_SAT), 64'd0);
    chk("rst_sat_cnt", 64'(SAT_CNT), 64'd0);
    tick();
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rel_in_ready", 64'(IN_READY), 64'd1);
    tick();
    // accept-to-output latency with a single sample
    IN_P = 48'h0000_0000_1800; IN_CARRY = 1'b1; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!OUT_VALID && lat < 10);
    chk("latency", 64'(lat), 64'd3);
    chk("lat_data", 64'(OUT_DATA), 64'd2);
    drain();
    send(48'hFFFF_FFFF_E800, 1'b1);
    send(48'h0000_0000_0800, 1'b0);
    send(48'h7FFF_FFFF_FFFF, 1'b1);
    drain();
    chk("sat_cnt_max", 64'(SAT_CNT), 64'd1);
    send(48'h8000_0000_0000, 1'b0);
    drain();
    chk("sat_cnt_min", 64'(SAT_CNT), 64'd2);
    for (int i = 0; i < 12; i++) begin
      v = $urandom;
      send(i[0] ? {16'($urandom), 32'(v)} : 48'(v), 1'($urandom));
    end
    drain();
    chk("sat_cnt_rand", 64'(SAT_CNT), 64'(sat_exp));
    CLR_CNT = 1'b1;
    tick();
    CLR_CNT = 1'b0;
    chk("clr_cnt", 64'(SAT_CNT), 64'd0);
    // clear asserted across the edge that writes a saturated entry
    send(48'h7FFF_FFFF_FFFF, 1'b0);
    CLR_CNT = 1'b1;
    tick();
    tick();
    CLR_CNT = 1'b0;
    drain();
    chk("clr_priority", 64'(SAT_CNT), 64'd0);
    sat_exp = 0;
    // backpressure: credit limit of four
    OUT_READY = 1'b0;
    a = n_acc;
    idx = 1;
    for (int i = 0; i < 8; i++) begin
      IN_P = 48'(idx * 4096);
      IN_CARRY = idx[0];
      IN_VALID = 1'b1;
      @(negedge CLK);
      if (IN_READY) idx++;
      tick();
    end
    IN_VALID = 1'b0;
    chk("bp_accepted", 64'(n_acc - a), 64'd4);
    @(negedge CLK);
    chk("bp_in_ready", 64'(IN_READY), 64'd0);
    tick();
    OUT_READY = 1'b1;
    for (int i = idx; i <= 8; i++) send(48'(i * 4096), 1'b0);
    drain();
    chk("bp_total", 64'(n_acc - a), 64'd8);
    // sustained throughput
    a = n_acc;
    o = n_out;
    stalls = 0;
    for (int i = 0; i < 24; i++) begin
      v = $urandom;
      IN_P = 48'(v);
      IN_CARRY = 1'($urandom);
      IN_VALID = 1'b1;
      @(negedge CLK);
      if (!IN_READY) stalls++;
      tick();
    end
    IN_VALID = 1'b0;
    chk("tp_accepted", 64'(n_acc - a), 64'd24);
    chk("tp_stalls", 64'(stalls), 64'd0);
    repeat (3) tick();
    chk("tp_outputs", 64'(n_out - o), 64'd24);
    drain();
    chk("sat_cnt_tp", 64'(SAT_CNT), 64'(sat_exp));
    // reset with two buffered and two in flight
    OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      IN_P = i == 0 ? 48'h7FFF_FFFF_FFFF : 48'(i * 4096);
      IN_VALID = 1'b1;
      tick();
    end
    IN_VALID = 1'b0;
    chk("pre_rst_valid", 64'(OUT_VALID), 64'd1);
    chk("pre_rst_sat_cnt", 64'(SAT_CNT), 64'(sat_exp + 1));
    RST_N = 1'b0;
    q.delete();
    sat_exp = 0;
    #1;
    chk("mid_rst_valid", 64'(OUT_VALID), 64'd0);
    chk("mid_rst_sat_cnt", 64'(SAT_CNT), 64'd0);
    chk("mid_rst_in_ready", 64'(IN_READY), 64'd0);
    chk("mid_rst_data", 64'(OUT_DATA), 64'd0);
    tick();
    RST_N = 1'b1;
    OUT_READY = 1'b1;
    o = n_out;
    repeat (10) tick();
    chk("no_stale_out", 64'(n_out - o), 64'd0);
    chk("no_stale_valid", 64'(OUT_VALID), 64'd0);
    send(48'h0000_0000_2800, 1'b1);
    drain();
    chk("post_rst_out", 64'(n_out - o), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
